// File: rtl/adder_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_arb_if
// Description : Requester and result handshake bundle for adder_share_arb.
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_share_arb_if #(
  parameter int N_REQ    = 4,
  parameter int A_WIDTH  = 8,
  parameter int B_WIDTH  = 8,
  parameter int ID_WIDTH = 2
);
  localparam int OUTPUT_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1;

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*A_WIDTH-1:0] req_a;
  logic [N_REQ*B_WIDTH-1:0] req_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [OUTPUT_WIDTH-1:0]  res_data;
  logic [ID_WIDTH-1:0]      res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface
`default_nettype wire

// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_arb
// Description : Round-robin arbiter sharing one extend-and-add datapath
//               between N_REQ requesters; results are tagged with the index.
//               Define ADDER_SHARE_ARB_OUT_REG_EN for an extra output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_arb #(
  parameter int    N_REQ       = 4,
  parameter int    A_WIDTH     = 8,
  parameter int    B_WIDTH     = 8,
  parameter string A_IS_SIGNED = "TRUE",
  parameter string B_IS_SIGNED = "TRUE",
  parameter int    ID_WIDTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_share_arb_if.slave bus,
  output logic             busy
);
  localparam int OUTPUT_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1;
  localparam int c_ptr_w      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam bit c_a_signed   = (A_IS_SIGNED == "TRUE");
  localparam bit c_b_signed   = (B_IS_SIGNED == "TRUE");

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
`ifdef ADDER_SHARE_ARB_OUT_REG_EN
    S_PIPE = 2'd3,
`endif
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [c_ptr_w-1:0]      r_ptr;
  logic [c_ptr_w-1:0]      r_tag;
  logic [OUTPUT_WIDTH-1:0] r_a_ext;
  logic [OUTPUT_WIDTH-1:0] r_b_ext;
  logic [OUTPUT_WIDTH-1:0] r_res_data;
  logic [ID_WIDTH-1:0]     r_res_id;
`ifdef ADDER_SHARE_ARB_OUT_REG_EN
  logic [OUTPUT_WIDTH-1:0] r_pipe_data;
  logic [ID_WIDTH-1:0]     r_pipe_id;
`endif

  logic                    w_found;
  logic [c_ptr_w-1:0]      w_grant;
  logic [A_WIDTH-1:0]      w_sel_a;
  logic [B_WIDTH-1:0]      w_sel_b;
  logic [OUTPUT_WIDTH-1:0] w_a_ext;
  logic [OUTPUT_WIDTH-1:0] w_b_ext;
  logic [OUTPUT_WIDTH-1:0] w_sum;
  logic                    w_take;
  logic [N_REQ-1:0]        w_req_ready;
  logic                    w_res_valid;

  // Search starts at the pointer so the most recently served requester goes last.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && bus.req_valid[(int'(r_ptr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_grant = c_ptr_w'((int'(r_ptr) + k) % N_REQ);
        w_sel_a = bus.req_a[((int'(r_ptr) + k) % N_REQ) * A_WIDTH +: A_WIDTH];
        w_sel_b = bus.req_b[((int'(r_ptr) + k) % N_REQ) * B_WIDTH +: B_WIDTH];
      end
    end
  end

  assign w_a_ext = {{(OUTPUT_WIDTH - A_WIDTH){c_a_signed & w_sel_a[A_WIDTH-1]}}, w_sel_a};
  assign w_b_ext = {{(OUTPUT_WIDTH - B_WIDTH){c_b_signed & w_sel_b[B_WIDTH-1]}}, w_sel_b};
  assign w_sum   = r_a_ext + r_b_ext;
  assign w_take  = (r_state == S_IDLE) && w_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = '0;
    w_res_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Ready is masked by reset so nothing looks accepted while held in reset.
        if (w_found && rst_n) begin
          w_req_ready[w_grant] = 1'b1;
          w_state_next         = S_ADD;
        end
      end
`ifdef ADDER_SHARE_ARB_OUT_REG_EN
      S_ADD:  w_state_next = S_PIPE;
      S_PIPE: w_state_next = S_RESP;
`else
      S_ADD:  w_state_next = S_RESP;
`endif
      S_RESP: begin
        w_res_valid = 1'b1;
        if (bus.res_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_tag      <= '0;
      r_a_ext    <= '0;
      r_b_ext    <= '0;
      r_res_data <= '0;
      r_res_id   <= '0;
`ifdef ADDER_SHARE_ARB_OUT_REG_EN
      r_pipe_data <= '0;
      r_pipe_id   <= '0;
`endif
    end else begin
      if (w_take) begin
        r_a_ext <= w_a_ext;
        r_b_ext <= w_b_ext;
        r_tag   <= w_grant;
        r_ptr   <= (w_grant == c_ptr_w'(N_REQ - 1)) ? '0 : w_grant + c_ptr_w'(1);
      end
`ifdef ADDER_SHARE_ARB_OUT_REG_EN
      if (r_state == S_ADD) begin
        r_pipe_data <= w_sum;
        r_pipe_id   <= ID_WIDTH'(r_tag);
      end
      if (r_state == S_PIPE) begin
        r_res_data <= r_pipe_data;
        r_res_id   <= r_pipe_id;
      end
`else
      if (r_state == S_ADD) begin
        r_res_data <= w_sum;
        r_res_id   <= ID_WIDTH'(r_tag);
      end
`endif
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.res_valid = w_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_id    = r_res_id;
  assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_share_arb
// Description : Self-checking bench for adder_share_arb (signed and unsigned
//               instances); honours ADDER_SHARE_ARB_OUT_REG_EN for latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_share_arb;
`ifdef ADDER_SHARE_ARB_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_ready;
  logic        busy_s;
  logic        busy_u;
  int          n_checks = 0;
  int          n_fail   = 0;

  adder_share_arb_if #(.N_REQ(4), .A_WIDTH(8), .B_WIDTH(8), .ID_WIDTH(2)) bus_s ();
  adder_share_arb_if #(.N_REQ(4), .A_WIDTH(8), .B_WIDTH(8), .ID_WIDTH(2)) bus_u ();

  assign bus_s.req_valid = req_valid;
  assign bus_s.req_a     = req_a;
  assign bus_s.req_b     = req_b;
  assign bus_s.res_ready = res_ready;
  assign bus_u.req_valid = req_valid;
  assign bus_u.req_a     = req_a;
  assign bus_u.req_b     = req_b;
  assign bus_u.res_ready = res_ready;

  adder_share_arb #(.N_REQ(4), .A_WIDTH(8), .B_WIDTH(8), .A_IS_SIGNED("TRUE"),
                    .B_IS_SIGNED("TRUE"), .ID_WIDTH(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .busy(busy_s));

  adder_share_arb #(.N_REQ(4), .A_WIDTH(8), .B_WIDTH(8), .A_IS_SIGNED("FALSE"),
                    .B_IS_SIGNED("FALSE"), .ID_WIDTH(2)) dut_u (
    .clk(clk), .rst_n(rst_n), .bus(bus_u), .busy(busy_u));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] msum(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    int x;
    int y;
    x = sgn ? int'($signed(a)) : int'(a);
    y = sgn ? int'($signed(b)) : int'(b);
    return 9'(x + y);
  endfunction

  // Reference model: idle / computing / responding, with a countdown to the result.
  int         m_ptr, m_phase, m_wait, m_pid, m_id;
  logic [8:0] m_pend_s, m_pend_u, m_data_s, m_data_u;

  always @(negedge clk) begin
    int         g;
    logic       found;
    logic [3:0] exp_ready;
    if (!rst_n) begin
      m_ptr = 0; m_phase = 0; m_wait = 0; m_pid = 0; m_id = 0;
      m_data_s = '0; m_data_u = '0; m_pend_s = '0; m_pend_u = '0;
    end
    found = 1'b0;
    g = 0;
    exp_ready = '0;
    if (rst_n && m_phase == 0) begin
      for (int k = 0; k < 4; k++) begin
        if (!found && req_valid[(m_ptr + k) % 4]) begin
          found = 1'b1;
          g = (m_ptr + k) % 4;
        end
      end
    end
    if (found) exp_ready[g] = 1'b1;
    chk("model_req_ready_s", 32'(bus_s.req_ready), 32'(exp_ready));
    chk("model_req_ready_u", 32'(bus_u.req_ready), 32'(exp_ready));
    chk("model_res_valid",   32'({bus_s.res_valid, bus_u.res_valid}), {30'd0, {2{m_phase == 2}}});
    chk("model_busy",        32'({busy_s, busy_u}), {30'd0, {2{m_phase != 0}}});
    chk("model_res_data_s",  32'(bus_s.res_data), 32'(m_data_s));
    chk("model_res_data_u",  32'(bus_u.res_data), 32'(m_data_u));
    chk("model_res_id",      32'({bus_s.res_id, bus_u.res_id}), 32'({m_id[1:0], m_id[1:0]}));
    if (rst_n) begin
      if (m_phase == 0 && found) begin
        m_ptr    = (g + 1) % 4;
        m_pend_s = msum(req_a[g*8 +: 8], req_b[g*8 +: 8], 1'b1);
        m_pend_u = msum(req_a[g*8 +: 8], req_b[g*8 +: 8], 1'b0);
        m_pid    = g;
        m_phase  = 1;
        m_wait   = LAT - 1;
      end else if (m_phase == 1) begin
        m_wait--;
        if (m_wait == 0) begin
          m_phase  = 2;
          m_data_s = m_pend_s;
          m_data_u = m_pend_u;
          m_id     = m_pid;
        end
      end else if (m_phase == 2 && res_ready) begin
        m_phase = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic idle;
    idle = 1'b0;
    for (int k = 0; k < 20 && !idle; k++) begin
      @(negedge clk);
      if (!busy_s) idle = 1'b1;
      tick();
    end
    chk("drain_idle", 32'(idle), 32'd1);
  endtask

  // Inputs must already be presented; checks the grant, then the tagged result.
  task automatic grant_result(input string name, input logic [3:0] mask, input int id,
                              input logic [8:0] es, input logic [8:0] eu);
    logic got;
    int   lat;
    got = 1'b0;
    lat = 0;
    @(negedge clk);
    chk({name, "_grant"}, 32'(bus_s.req_ready), 32'(mask));
    tick();
    req_valid = '0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (bus_s.res_valid) begin
        got = 1'b1;
        lat = k;
      end else begin
        tick();
      end
    end
    chk({name, "_seen"},    32'(got), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'(LAT));
    chk({name, "_data_s"},  32'(bus_s.res_data), 32'(es));
    chk({name, "_data_u"},  32'(bus_u.res_data), 32'(eu));
    chk({name, "_id"},      32'(bus_s.res_id), 32'(id));
    tick();
  endtask

  task automatic run_single(input string name, input int lane, input logic [7:0] a,
                            input logic [7:0] b, input logic [8:0] es, input logic [8:0] eu);
    req_a[lane*8 +: 8] = a;
    req_b[lane*8 +: 8] = b;
    req_valid          = 4'(1 << lane);
    res_ready          = 1'b1;
    grant_result(name, 4'(1 << lane), lane, es, eu);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ids[5];
    int cyc[5];
    int nres;
    int t;
    logic got;
    rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",      32'({busy_s, busy_u}), 32'd0);
    chk("reset_res_valid", 32'(bus_s.res_valid), 32'd0);
    chk("reset_res_data",  32'(bus_s.res_data), 32'd0);
    chk("reset_res_id",    32'(bus_s.res_id), 32'd0);
    tick();
    rst_n = 1'b1;

    run_single("single_7f_01", 2, 8'h7F, 8'h01, 9'h080, 9'h080);
    run_single("ext_ff_ff",    0, 8'hFF, 8'hFF, 9'h1FE, 9'h1FE);
    run_single("ext_80_ff",    1, 8'h80, 8'hFF, 9'h17F, 9'h17F);
    run_single("ext_ff_01",    3, 8'hFF, 8'h01, 9'h000, 9'h100);

    // Fairness with all requesters active; pointer is back at 0 here.
    req_a = 32'h31_21_11_01;
    req_b = 32'h03_02_01_00;
    req_valid = 4'hF;
    res_ready = 1'b1;
    nres = 0;
    t = 0;
    while (nres < 5 && t < 60) begin
      @(negedge clk);
      if (bus_s.res_valid) begin
        ids[nres] = int'(bus_s.res_id);
        cyc[nres] = t;
        nres++;
      end
      tick();
      t++;
    end
    req_valid = '0;
    chk("rr_count", 32'(nres), 32'd5);
    chk("rr_id0", 32'(ids[0]), 32'd0);
    chk("rr_id1", 32'(ids[1]), 32'd1);
    chk("rr_id2", 32'(ids[2]), 32'd2);
    chk("rr_id3", 32'(ids[3]), 32'd3);
    chk("rr_id4", 32'(ids[4]), 32'd0);
    for (int j = 1; j < 5; j++) chk("rr_period", 32'(cyc[j] - cyc[j-1]), 32'(LAT + 1));
    drain();

    // Backpressure: result held while others wait.
    req_a[7:0] = 8'h10;
    req_b[7:0] = 8'h20;
    req_valid  = 4'b0001;
    res_ready  = 1'b0;
    @(negedge clk);
    chk("bp_grant", 32'(bus_s.req_ready), 32'b0001);
    tick();
    req_valid = 4'b1110;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (bus_s.res_valid) got = 1'b1;
      tick();
    end
    chk("bp_seen", 32'(got), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", {bus_s.res_valid, bus_s.req_ready, bus_s.res_id, 16'd0, 7'd0, bus_s.res_data},
          {1'b1, 4'b0000, 2'd0, 16'd0, 7'd0, 9'h030});
      tick();
    end
    res_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("bp_next_grant", 32'(bus_s.req_ready), 32'b0010);
    tick();
    req_valid = '0;
    drain();

    // Asynchronous reset while an operation is in flight.
    req_a[15:8]  = 8'h55; req_b[15:8]  = 8'h11;
    req_a[31:24] = 8'h03; req_b[31:24] = 8'h04;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("rst_pre_grant", 32'(bus_s.req_ready), 32'b0010);
    tick();
    req_valid = 4'b1000;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {busy_s, bus_s.res_valid, bus_s.req_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    grant_result("rst_after", 4'b1000, 3, 9'h007, 9'h007);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter that time-shares one extend-and-add datapath between N_REQ requesters.
- Each requester presents an operand pair on a valid/ready handshake.
- The block grants one requester and captures its operands, performs one full-precision add, then returns the sum tagged with the requester index on a valid/ready result channel.
- Used wherever several low-rate accumulation/offset paths share one adder instead of instantiating one each.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- A_WIDTH, 8, width of each requester's operand a.
- B_WIDTH, 8, width of each requester's operand b.
- A_IS_SIGNED, "TRUE", "TRUE" sign-extends a, anything else zero-extends.
- B_IS_SIGNED, "TRUE", same rule for b.
- ID_WIDTH, 2, width of the result tag; must be >= ceil(log2(N_REQ)).
- OUTPUT_WIDTH (localparam), max(A_WIDTH,B_WIDTH)+1, sum width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  bit i: requester i has an operand pair.
- req_ready  out  N_REQ  bit i: requester i's pair is accepted this cycle.
- req_a  in  N_REQ*A_WIDTH  requester i operand a at [i*A_WIDTH +: A_WIDTH].
- req_b  in  N_REQ*B_WIDTH  requester i operand b at [i*B_WIDTH +: B_WIDTH].
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  OUTPUT_WIDTH  a_ext + b_ext.
- res_id  out  ID_WIDTH  index of the requester that produced res_data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, async):
  - State = IDLE, rr pointer = 0.
  - req_ready = 0, res_valid = 0, res_data = 0, res_id = 0, busy = 0.
  - Any in-flight operation is discarded and no result is emitted.
  - A requester already handshaken is considered served and must not expect a result.
- States: IDLE -> ADD -> [PIPE, macro only] -> RESP -> IDLE.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo N_REQ.
  - req_ready is one-hot at bit g and combinational from req_valid in IDLE only; zero in every other state.
  - With no valid request, req_ready = 0 and the block stays in IDLE.
  - On grant, the extended operands are registered, the tag is set to g, ptr <= (g+1) mod N_REQ, and the state goes to ADD.
- ADD:
  - sum = a_ext + b_ext computed at OUTPUT_WIDTH.
  - Extension per the *_IS_SIGNED parameters; overflow is impossible.
  - Result goes into res_data/res_id registers, then next state.
- RESP:
  - res_valid = 1; res_data and res_id are held stable until res_ready = 1.
  - On res_valid & res_ready the state goes to IDLE and res_valid drops the next cycle.
  - res_data/res_id keep their last value after the handshake.
- Latency: grant cycle T -> res_valid high at T+2; with the macro, T+3.
- Throughput with res_ready held high: one result per 3 cycles (4 with the macro).
- A requester dropping req_valid while not granted is legal and has no effect.
- req_valid changes during ADD/RESP are ignored until the next IDLE.
- ptr advances only on an accepted grant; a single persistent requester is re-granted every pass.
- Backpressure: RESP can hold indefinitely with no loss; no new grant occurs while RESP is pending.

Optional Feature:
- Macro ADDER_SHARE_ARB_OUT_REG_EN.
- Defined: an extra PIPE state registers the adder output once more before RESP. Grant-to-res_valid latency becomes 3 cycles, for timing closure on wide operands. Arbitration, handshake and reset rules are unchanged.
- Undefined: no PIPE state; latency is 2 cycles.

Test Plan:
- Single request: N_REQ=4, signed, req_valid=4'b0100, a=8'h7F, b=8'h01, res_ready=1 -> req_ready=4'b0100 for one cycle; res_valid 2 cycles later with res_data=9'h080, res_id=2.
- Signed/unsigned extension:
  - Signed: a=8'hFF, b=8'hFF -> res_data=9'h1FE (-2).
  - A_IS_SIGNED=B_IS_SIGNED="FALSE": same inputs -> res_data=9'h1FE (510). Check the 9-bit value plus the parameter interpretation.
  - Signed: a=8'h80, b=8'hFF -> res_data=9'h17F.
- Round-robin fairness: all four req_valid held high, res_ready=1 -> res_id sequence 0,1,2,3,0; each grant 3 cycles apart.
- Backpressure: res_ready=0 for 10 cycles during RESP with other req_valid high -> res_valid, res_data, res_id stable; req_ready=0 throughout; the next grant happens only after the handshake.
- Async reset mid-operation: assert rst_n=0 during ADD -> res_valid, req_ready, busy go 0 immediately. After release with req_valid=4'b1000, the grant goes to 3 (ptr restarted at 0), and no stale result appears.
- Macro build: repeat the single-request case with ADDER_SHARE_ARB_OUT_REG_EN defined -> res_valid 3 cycles after the grant, same data; fairness sequence period 4 cycles.
